// File: rtl/icache_resp.sv
// icache_resp: direct-mapped 64x4-word instruction cache with uncached kseg1 path.
// One fetch in flight; refills drain to completion even after a cancel.
module icache_resp (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   input  logic        cancel,
   output logic        icache_ask,
   output logic        icache_stall,
   output logic [31:0] inst_rdata,
   output logic        rd_req,
   output logic        rd_type,
   output logic [31:0] rd_addr,
   input  logic        rd_rdy,
   input  logic        ret_valid,
   input  logic        ret_last,
   input  logic [31:0] ret_data
);
   typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, UC_REQ, UC_WAIT, RESP} state_t;
   state_t      r_state, w_next;
   logic [31:2] r_paddr;
   logic        r_uc;
   logic [1:0]  r_cnt;
   logic        r_drop;
   logic [63:0] r_valid;
   logic [21:0] r_tag [64];
   logic [31:0] r_data [256];
   logic [5:0]  w_idx;
   logic [1:0]  w_off;
   logic        w_hit, w_beat, w_last, w_drop, w_busy;
   logic [31:0] w_word;
   logic        w_unused;
   assign w_unused = &{1'b0, inst_sram_addr[1:0]};
   assign w_idx  = r_paddr[9:4];
   assign w_off  = r_paddr[3:2];
   assign w_hit  = !r_uc && r_valid[w_idx] && r_tag[w_idx] == r_paddr[31:10];
   assign w_beat = r_state == REFILL && ret_valid;
   assign w_last = w_beat && ret_last;
   assign w_drop = r_drop || cancel;
   // the requested word may be arriving on this very beat
   assign w_word = r_cnt == w_off ? ret_data : r_data[{w_idx, w_off}];
   assign w_busy = w_next inside {MISS, REFILL, UC_REQ, UC_WAIT};
   always_comb begin
      w_next       = r_state;
      icache_stall = 1'b0;
      rd_req       = 1'b0;
      rd_type      = 1'b0;
      rd_addr      = 32'h0;
      icache_ask   = inst_sram_en && (r_state == IDLE || r_state == RESP ||
                     (r_state == LOOKUP && w_hit && !cancel));
      case (r_state)
         IDLE:    w_next = icache_ask ? LOOKUP : IDLE;
         LOOKUP: begin
            icache_stall = !w_hit && !cancel;
            w_next       = cancel ? IDLE : w_hit ? (icache_ask ? LOOKUP : IDLE) : r_uc ? UC_REQ : MISS;
         end
         MISS: begin
            icache_stall = 1'b1;
            rd_req       = 1'b1;
            rd_type      = 1'b1;
            rd_addr      = {r_paddr[31:4], 4'b0};
            w_next       = rd_rdy ? REFILL : cancel ? IDLE : MISS;
         end
         REFILL: begin
            icache_stall = 1'b1;
            w_next       = w_last ? (w_drop ? IDLE : RESP) : REFILL;
         end
         UC_REQ: begin
            icache_stall = 1'b1;
            rd_req       = 1'b1;
            rd_addr      = {r_paddr, 2'b0};
            w_next       = rd_rdy ? UC_WAIT : cancel ? IDLE : UC_REQ;
         end
         UC_WAIT: begin
            icache_stall = 1'b1;
            w_next       = ret_valid ? (w_drop ? IDLE : RESP) : UC_WAIT;
         end
         RESP:    w_next = icache_ask ? LOOKUP : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_paddr    <= '0;
         r_uc       <= 1'b0;
         r_cnt      <= 2'd0;
         r_drop     <= 1'b0;
         r_valid    <= '0;
         inst_rdata <= 32'h0;
      end else begin
         r_state <= w_next;
         if (icache_ask) begin
            r_paddr <= {3'b000, inst_sram_addr[28:2]};
            r_uc    <= inst_sram_addr[31:29] == 3'b101;
         end
         r_cnt  <= w_last ? 2'd0 : w_beat ? r_cnt + 2'd1 : r_cnt;
         r_drop <= w_busy && w_drop;
         if (w_last) r_valid[w_idx] <= 1'b1;
         if (r_state == LOOKUP && w_hit && !cancel) inst_rdata <= r_data[{w_idx, w_off}];
         else if (w_last && !w_drop) inst_rdata <= w_word;
         else if (r_state == UC_WAIT && ret_valid && !w_drop) inst_rdata <= ret_data;
      end
   end
   always_ff @(posedge clk) begin
      if (w_beat) r_data[{w_idx, r_cnt}] <= ret_data;
      if (w_last) r_tag[w_idx] <= r_paddr[31:10];
   end
endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed fetch sequence for icache_resp with an inst_rdata scoreboard.
module tb_icache_resp;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        inst_sram_en = 1'b0, cancel = 1'b0;
   logic [31:0] inst_sram_addr = 32'h0;
   logic        icache_ask, icache_stall, rd_req, rd_type;
   logic [31:0] inst_rdata, rd_addr;
   logic        rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0;
   logic [31:0] ret_data = 32'h0;
   logic [31:0] sb [$];
   logic [31:0] held;
   int          checks = 0, errors = 0;
   icache_resp dut (
      .clk(clk), .rst_n(rst_n), .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
      .cancel(cancel), .icache_ask(icache_ask), .icache_stall(icache_stall), .inst_rdata(inst_rdata),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic [31:0] a, input bit push, input logic [31:0] exp);
      inst_sram_en   = 1'b1;
      inst_sram_addr = a;
      #1 chk("ask", {31'b0, icache_ask}, 32'd1);
      if (push) sb.push_back(exp);
      @(negedge clk);
      inst_sram_en = 1'b0;
   endtask
   task automatic serve(input logic t, input logic [31:0] a, input logic [127:0] d, input int cb);
      int n = t ? 4 : 1;
      bit seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         #1;
         if (rd_req) seen = 1'b1;
         else @(negedge clk);
      end
      chk("rd_req_seen", {31'b0, seen}, 32'd1);
      if (!seen) return;
      chk("rd_type", {31'b0, rd_type}, {31'b0, t});
      chk("rd_addr", rd_addr, a);
      rd_rdy = 1'b1;
      @(negedge clk);
      rd_rdy = 1'b0;
      for (int b = 0; b < n; b++) begin
         ret_valid = 1'b1;
         ret_data  = d[32*b +: 32];
         ret_last  = b == n - 1;
         cancel    = b == cb;
         @(negedge clk);
      end
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      cancel    = 1'b0;
   endtask
   task automatic deliver();
      bit ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         #1;
         if (!icache_stall) ok = 1'b1;
         else @(negedge clk);
      end
      chk("stall_release", {31'b0, ok}, 32'd1);
      @(negedge clk);
      #1;
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else chk("rdata", inst_rdata, sb.pop_front());
   endtask
   initial begin
      #2;
      chk("rst_stall", {31'b0, icache_stall}, 32'd0);
      chk("rst_rd_req", {31'b0, rd_req}, 32'd0);
      chk("rst_rd_type", {31'b0, rd_type}, 32'd0);
      chk("rst_rd_addr", rd_addr, 32'h0);
      chk("rst_rdata", inst_rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // uncached boot fetch
      issue(32'hBFC00000, 1'b1, 32'h3C080000);
      #1 chk("uc_lookup_stall", {31'b0, icache_stall}, 32'd1);
      serve(1'b0, 32'h1FC00000, {96'h0, 32'h3C080000}, -1);
      deliver();
      // cold miss then hit in the same line
      issue(32'h80000008, 1'b1, 32'h33);
      serve(1'b1, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
      deliver();
      issue(32'h8000000C, 1'b1, 32'h44);
      #1 chk("hit_stall", {31'b0, icache_stall}, 32'd0);
      chk("hit_no_req", {31'b0, rd_req}, 32'd0);
      deliver();
      // back-to-back hits with en held
      issue(32'h80000000, 1'b1, 32'h11);
      inst_sram_en = 1'b1; inst_sram_addr = 32'h80000004;
      #1 chk("b2b_ask1", {31'b0, icache_ask}, 32'd1);
      chk("b2b_stall1", {31'b0, icache_stall}, 32'd0);
      sb.push_back(32'h22);
      @(negedge clk);
      #1 chk("b2b_rdata0", inst_rdata, sb.pop_front());
      inst_sram_addr = 32'h80000008;
      #1 chk("b2b_ask2", {31'b0, icache_ask}, 32'd1);
      chk("b2b_stall2", {31'b0, icache_stall}, 32'd0);
      sb.push_back(32'h33);
      @(negedge clk);
      #1 chk("b2b_rdata1", inst_rdata, sb.pop_front());
      inst_sram_en = 1'b0;
      #1 chk("b2b_stall3", {31'b0, icache_stall}, 32'd0);
      @(negedge clk);
      #1 chk("b2b_rdata2", inst_rdata, sb.pop_front());
      // conflict miss replaces tag at index 0
      issue(32'h80000400, 1'b1, 32'hA0);
      serve(1'b1, 32'h400, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1);
      deliver();
      issue(32'h80000000, 1'b1, 32'h11);
      #1 chk("evict_miss", {31'b0, icache_stall}, 32'd1);
      serve(1'b1, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, -1);
      deliver();
      // cancel in lookup
      held = inst_rdata;
      issue(32'h80000004, 1'b0, 32'h0);
      cancel = 1'b1;
      #1 chk("lk_cancel_req", {31'b0, rd_req}, 32'd0);
      @(negedge clk);
      cancel = 1'b0;
      #1 chk("lk_cancel_rdata", inst_rdata, held);
      // cancel on refill beat 2 drains the burst
      issue(32'h80000014, 1'b0, 32'h0);
      serve(1'b1, 32'h10, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2);
      #1 chk("drain_stall", {31'b0, icache_stall}, 32'd0);
      chk("drain_rdata", inst_rdata, held);
      @(negedge clk);
      issue(32'h80000014, 1'b1, 32'hB1);
      #1 chk("drain_hit", {31'b0, rd_req | icache_stall}, 32'd0);
      deliver();
      // cancel in MISS before rd_rdy, then stray beat while idle
      held = inst_rdata;
      issue(32'h80000020, 1'b0, 32'h0);
      @(negedge clk);
      #1 chk("miss_req", {31'b0, rd_req}, 32'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      #1 chk("miss_cancel_req", {31'b0, rd_req}, 32'd0);
      chk("miss_cancel_stall", {31'b0, icache_stall}, 32'd0);
      ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hDEADBEEF;
      @(negedge clk);
      ret_valid = 1'b0; ret_last = 1'b0;
      #1 chk("stray_rdata", inst_rdata, held);
      issue(32'h80000020, 1'b1, 32'hC0);
      #1 chk("stray_no_fill", {31'b0, icache_stall}, 32'd1);
      serve(1'b1, 32'h20, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, -1);
      deliver();
      // reset mid-refill leaves the line invalid
      issue(32'h80000030, 1'b0, 32'h0);
      serve(1'b1, 32'h30, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, -1);
      issue(32'h80000034, 1'b0, 32'h0);
      #1 chk("line_hit", {31'b0, icache_stall}, 32'd0);
      @(negedge clk);
      issue(32'h80000040, 1'b0, 32'h0);
      @(negedge clk);
      rd_rdy = 1'b1;
      @(negedge clk);
      rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = 32'hE0;
      @(negedge clk);
      rst_n = 1'b0; ret_valid = 1'b0;
      #1 chk("mid_rst_req", {31'b0, rd_req}, 32'd0);
      chk("mid_rst_rdata", inst_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(32'h80000040, 1'b1, 32'hF0);
      #1 chk("rst_line_invalid", {31'b0, icache_stall}, 32'd1);
      serve(1'b1, 32'h40, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, -1);
      deliver();
      chk("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/icache_resp.md
ICACHE_RESP -- requirements
Module: icache_resp

Interface
REQ-001 SHALL have clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have inst_sram_en  input  1  fetch request valid from the PC stage.
REQ-004 SHALL have inst_sram_addr  input  32  virtual fetch address; bits [1:0] ignored.
REQ-005 SHALL have cancel  input  1  flush; drop any pending response.
REQ-006 SHALL have icache_ask  output  1  request accepted this cycle (combinational).
REQ-007 SHALL have icache_stall  output  1  accepted request not yet answered.
REQ-008 SHALL have inst_rdata  output  32  returned instruction word, registered.
REQ-009 SHALL have rd_req  output  1, rd_type  output  1 (1 = 4-word burst, 0 = single word), and rd_addr  output  32  physical address.
REQ-010 SHALL have rd_rdy  input  1  memory accepted rd_req.
REQ-011 SHALL have ret_valid  input  1, ret_last  input  1, ret_data  input  32  read-return beats.

Function
REQ-012 SHALL be direct-mapped: 64 lines x 4 words; index = paddr[9:4], offset = paddr[3:2], tag = paddr[31:10]; one valid bit per line.
REQ-013 SHALL translate paddr = {3'b000, addr[28:0]}; addr[31:29]=3'b101 (kseg1) is uncached; all other addresses are cached.
REQ-014 SHALL use FSM states IDLE, LOOKUP, MISS, REFILL, UC_REQ, UC_WAIT, RESP.
REQ-015 SHALL assert icache_ask = inst_sram_en & (state IDLE | RESP | (LOOKUP & hit & !cancel)), and SHALL register paddr when asserted.
REQ-016 SHALL go from IDLE to LOOKUP on icache_ask.
REQ-017 LOOKUP, cached hit: icache_stall=0; inst_rdata <= line word at the next edge; next state LOOKUP if icache_ask, else IDLE.
REQ-018 LOOKUP, cached miss: icache_stall=1; next state MISS. Uncached: icache_stall=1; next state UC_REQ.
REQ-019 MISS: rd_req=1, rd_type=1, rd_addr={paddr[31:4],4'b0}; hold until rd_rdy; then go to REFILL.
REQ-020 REFILL: a 2-bit beat counter starting at 0 SHALL write ret_data into word[counter] on each ret_valid; on ret_valid&ret_last it SHALL set valid, write tag, and go to RESP.
REQ-021 UC_REQ: rd_req=1, rd_type=0, rd_addr={paddr[31:2],2'b0}; on rd_rdy go to UC_WAIT. UC_WAIT: on ret_valid go to RESP; data is not cached.
REQ-022 Transition into RESP SHALL load inst_rdata with the requested word (burst word at offset, or uncached beat). RESP: icache_stall=0; next state LOOKUP if icache_ask, else IDLE.
REQ-023 icache_stall SHALL be 1 in MISS, REFILL, UC_REQ and UC_WAIT.
REQ-024 inst_rdata SHALL hold its value until the next delivery.
REQ-025 cancel in LOOKUP: no memory request, no inst_rdata update; next state IDLE.
REQ-026 cancel in MISS/UC_REQ before rd_rdy: drop the request; next state IDLE.
REQ-027 cancel after rd_rdy: the transaction SHALL drain (refill still written and validated); on the last beat go to IDLE, not RESP; inst_rdata unchanged.
REQ-028 Once asserted, rd_req and rd_addr SHALL stay stable until rd_rdy, except on cancel per REQ-026.
REQ-029 SHALL ignore ret_valid outside REFILL and UC_WAIT.

Reset
REQ-030 On rst_n=0: state IDLE, all valid bits 0, icache_stall=0, rd_req=0, rd_type=0, rd_addr=0, inst_rdata=0, beat counter 0.
REQ-031 Reset mid-refill SHALL abandon the burst; the line stays invalid.

Verification
REQ-032 Fetch 0xBFC00000 after reset -> LOOKUP uncached; rd_req, rd_type=0, rd_addr=0x1FC00000; ret_data=0x3C080000 -> RESP, stall 0, inst_rdata=0x3C080000.
REQ-033 Fetch 0x80000008, cold -> burst rd_addr=0x00000000; beats 0x11,0x22,0x33,0x44 -> inst_rdata=0x33; then fetch 0x8000000C -> hit, no rd_req, inst_rdata=0x44 after one cycle.
REQ-034 Back-to-back hits 0x80000000, 0x80000004, 0x80000008 with en held -> icache_ask=1 each cycle, stall never 1, one word per cycle.
REQ-035 Miss 0x80000400 (index 0, new tag) while 0x80000000 is valid -> refill replaces the tag; re-fetch 0x80000000 misses.
REQ-036 cancel during REFILL beat 2 -> remaining beats accepted, back to IDLE, inst_rdata unchanged; next fetch of that line hits.
REQ-037 cancel in MISS with rd_rdy=0 -> rd_req drops next cycle; no beats consumed.
